// File: rtl/alu_hilo_if.sv
// Operand, control and result bundle for the HI/LO ALU.
interface alu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [5:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, ctl, a, b, shamt,
        input  result, zero, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, ctl, a, b, shamt,
        output result, zero, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_hilo.sv
// Combinational ALU with a multi-cycle unsigned restoring divider writing HI/LO.
module alu_hilo #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_hilo_if.slave bus
);
    localparam logic [5:0] CTL_SLL  = 6'd0;
    localparam logic [5:0] CTL_MFHI = 6'd16;
    localparam logic [5:0] CTL_MFLO = 6'd18;
    localparam logic [5:0] CTL_DIVU = 6'd27;
    localparam logic [5:0] CTL_ADD  = 6'd32;
    localparam logic [5:0] CTL_SUB  = 6'd34;
    localparam logic [5:0] CTL_AND  = 6'd36;
    localparam logic [5:0] CTL_OR   = 6'd37;
    localparam logic [5:0] CTL_SLT  = 6'd42;

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [5:0]       cnt_reg;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dq_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;
    logic             busy;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dq_step;
    logic [WIDTH-1:0] result;

    // A divide is only taken when idle; the done cycle is already idle.
    assign accept    = (state_reg == IDLE) && bus.op_valid && (bus.ctl == CTL_DIVU);
    assign last_step = (state_reg == DIV) && (cnt_reg == 6'(WIDTH - 1));

    // One restoring step: no borrow from the trial subtraction means remainder >= divisor.
    always_comb begin
        rem_shift = {rem_reg, dq_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_reg};
        q_bit     = ~rem_diff[WIDTH];
        rem_step  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        dq_step   = {dq_reg[WIDTH-2:0], q_bit};
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Divider next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = DIV;
            DIV:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divider status output.
    always_comb begin
        busy = (state_reg == DIV);
    end

    // Divider datapath: load operands on accept, then one step per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg     <= '0;
            dq_reg      <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
        end else if (accept) begin
            cnt_reg     <= '0;
            dq_reg      <= bus.a;
            divisor_reg <= bus.b;
            rem_reg     <= '0;
        end else if (state_reg == DIV) begin
            cnt_reg     <= cnt_reg + 6'd1;
            dq_reg      <= dq_step;
            rem_reg     <= rem_step;
        end
    end

    // HI/LO are written only by the final step; a reset mid-divide clears them instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= last_step;
            if (last_step) begin
                hi_reg <= rem_step;
                lo_reg <= dq_step;
            end
        end
    end

    // ALU result; independent of op_valid and of divider activity.
    always_comb begin
        result = '0;
        case (bus.ctl)
            CTL_ADD:  result = bus.a + bus.b;
            CTL_SUB:  result = bus.a - bus.b;
            CTL_AND:  result = bus.a & bus.b;
            CTL_OR:   result = bus.a | bus.b;
            CTL_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            CTL_SLL:  result = bus.b << bus.shamt;
            CTL_MFHI: result = hi_reg;
            CTL_MFLO: result = lo_reg;
            default:  result = '0;
        endcase
    end

    assign bus.result = result;
    assign bus.zero   = (result == '0);
    assign bus.busy   = busy;
    assign bus.done   = done_reg;
    assign bus.hi     = hi_reg;
    assign bus.lo     = lo_reg;
endmodule

// File: doc/alu_hilo.md
ALU_HILO -- requirements
Module: alu_hilo

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of a, b, result, HI and LO.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 op_valid  input  1  ctl, a, b and shamt are valid this cycle.
REQ-005 ctl  input  6  ALU operation code: add=32, sub=34, and=36, or=37, slt=42, sll=0, divu=27, mfhi=16, mflo=18.
REQ-006 a  input  WIDTH  operand A (rs).
REQ-007 b  input  WIDTH  operand B (rt or immediate).
REQ-008 shamt  input  5  shift amount for sll.
REQ-009 result  output  WIDTH  combinational operation result.
REQ-010 zero  output  1  high when result == 0.
REQ-011 busy  output  1  divide in progress; the pipeline stalls on it.
REQ-012 done  output  1  one-cycle pulse when HI/LO receive a divide result.
REQ-013 hi, lo  output  WIDTH each  current HI and LO register contents.

Function
REQ-014 The block SHALL compute result combinationally from the current ctl, a, b, shamt, HI and LO, independent of op_valid and busy.
REQ-015 add SHALL give a+b, and sub SHALL give a-b, both modulo 2^WIDTH with no overflow flag.
REQ-016 and and or SHALL give the bitwise a&b and a|b.
REQ-017 slt SHALL give 1 when a < b as two's-complement signed values, otherwise 0.
REQ-018 sll SHALL give b shifted left by shamt, with zero fill.
REQ-019 mfhi SHALL give the HI register value, and mflo SHALL give the LO register value.
REQ-020 divu and any unlisted ctl code SHALL give result 0.
REQ-021 The divider SHALL have two states, IDLE and DIV, plus a 6-bit step counter.
REQ-022 In IDLE, op_valid=1 with ctl=27 SHALL accept a divide at the edge (E0): latch dividend=a and divisor=b, clear the remainder, set counter=0 and move to DIV.
REQ-023 In DIV, each edge SHALL perform one unsigned restoring step: shift the next dividend MSB into the remainder, subtract the divisor if the remainder >= divisor, shift the quotient bit in, and increment the counter.
REQ-024 At the WIDTH-th step edge (E32), the block SHALL write LO=quotient and HI=remainder, return to IDLE and assert done for exactly the following cycle.
REQ-025 busy SHALL be high for exactly WIDTH cycles, the cycles following E0 through E32; it is low in the done cycle.
REQ-026 A divu presented while busy=1 SHALL be ignored, with no queueing and no effect on the running divide.
REQ-027 A divu presented in the done cycle SHALL be accepted, giving back-to-back divides.
REQ-028 While busy, mfhi/mflo SHALL return the previous HI/LO values; the written values become visible from the done cycle onward.
REQ-029 Divide by zero SHALL run the full WIDTH steps and yield LO=all ones and HI=dividend, with no exception.
REQ-030 HI and LO SHALL change only at E32 or on reset.

Reset
REQ-031 On a clk edge with rst=0, the block SHALL force: state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0.
REQ-032 A reset during DIV SHALL abort the divide: no done pulse, and HI/LO are cleared rather than updated.
REQ-033 After reset, result SHALL follow REQ-014..020 with HI=LO=0; for example mfhi gives 0.
REQ-034 The first divu SHALL be accepted on the first edge with rst=1.

Verification
REQ-035 add: a=0x7FFFFFFF, b=1 -> result 0x80000000, zero=0; sub: a=5, b=5 -> result 0, zero=1.
REQ-036 slt: a=0xFFFFFFFF, b=1 -> result 1; sll: b=1, shamt=31 -> result 0x80000000; ctl=63 -> result 0.
REQ-037 divu: a=100, b=7 -> busy for 32 cycles, one done pulse, then mflo=14 and mfhi=2; mfhi read during busy returns the prior HI.
REQ-038 divu by zero: a=0x1234, b=0 -> after 32 cycles LO=0xFFFFFFFF and HI=0x1234.
REQ-039 Reset mid-divide: rst=0 at step 10 -> next cycle busy=0, HI=LO=0, and no done pulse follows.
REQ-040 A second divu issued at step 5 is ignored; a divu (a=9, b=2) issued in the done cycle is accepted and completes 32 cycles later with LO=4 and HI=1.
